// File: rtl/ps2_rx_fifo_pkg.sv
// rtl/ps2_rx_fifo_pkg.sv - shared PS/2 frame constants, entry layout and frame check
package ps2_rx_fifo_pkg;

  localparam int PS2_FRAME_BITS = 11;
  localparam int ENTRY_W        = 10;
  localparam int ENT_EXT        = 9;
  localparam int ENT_BRK        = 8;
  localparam int ENT_DATA_MSB   = 7;

  localparam logic [7:0] PS2_CODE_EXT = 8'hE0;
  localparam logic [7:0] PS2_CODE_BRK = 8'hF0;

  // Index of the stop bit; the frame is evaluated when the counter sits here.
  localparam logic [3:0] PS2_LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  typedef enum logic [1:0] {
    FR_GOOD   = 2'd0,
    FR_PARITY = 2'd1,
    FR_FRAME  = 2'd2
  } frame_res_e;

  // Framing errors take precedence over parity errors.
  function automatic frame_res_e frame_check(
    input logic       start_bit,
    input logic [7:0] data,
    input logic       parity,
    input logic       stop_bit
  );
    if (start_bit != 1'b0 || stop_bit != 1'b1) return FR_FRAME;
    if ((^{data, parity}) == 1'b0) return FR_PARITY;
    return FR_GOOD;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// rtl/ps2_rx_fifo_sync_fifo.sv - show-ahead ready/valid FIFO with occupancy output
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  // The extra pointer MSB separates the full and empty cases when the indices match.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign in_ready  = !w_full || w_pop;
  assign w_push    = in_valid && in_ready;
  assign out_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign level     = r_wr_ptr - r_rd_ptr;

  // Pointer advance on accepted push and pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until the pointers expose them.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= in_data;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 device-to-host receiver with prefix merge, watchdog and output FIFO
module ps2_rx_fifo
  import ps2_rx_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int DECODE_PREFIX  = 1
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              ps2_clk,
  input  logic                              ps2_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [7:0]                        out_data,
  output logic                              out_ext,
  output logic                              out_break,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              err_parity,
  output logic                              err_frame,
  output logic                              err_overflow,
  output logic                              err_timeout
);

  localparam int              WDW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0]  WD_LIMIT  = WDW'(TIMEOUT_CYCLES);
  localparam bit              PREFIX_EN = (DECODE_PREFIX != 0);

  logic [SYNC_STAGES-1:0] r_sync_clk;
  logic [SYNC_STAGES-1:0] r_sync_dat;
  logic [3:0]             r_bit_cnt;
  logic [9:0]             r_shift;
  logic [WDW-1:0]         r_wd_cnt;
  logic                   r_ext_pend;
  logic                   r_brk_pend;
  logic                   r_err_parity;
  logic                   r_err_frame;
  logic                   r_err_overflow;
  logic                   r_err_timeout;

  logic                   w_fall;
  logic                   w_bit;
  logic                   w_eval;
  frame_res_e             w_result;
  logic [7:0]             w_data;
  logic                   w_good;
  logic                   w_is_ext;
  logic                   w_is_brk;
  logic                   w_push;
  logic                   w_timeout;
  logic                   w_clear_pend;
  logic [ENTRY_W-1:0]     w_entry;
  logic [ENTRY_W-1:0]     w_head;
  logic                   w_fifo_valid;
  logic                   w_fifo_in_ready;

  // Newest sample enters at bit 0; both lines use the same depth so they stay aligned.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync_clk <= '1;
      r_sync_dat <= '1;
    end else begin
      r_sync_clk <= {r_sync_clk[SYNC_STAGES-2:0], ps2_clk};
      r_sync_dat <= {r_sync_dat[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign w_fall = r_sync_clk[SYNC_STAGES-1] & ~r_sync_clk[SYNC_STAGES-2];
  assign w_bit  = r_sync_dat[SYNC_STAGES-1];

  // Shift buffer after 10 bits: [0]=start, [8:1]=data, [9]=parity; the stop bit is taken live.
  assign w_eval    = w_fall && (r_bit_cnt == PS2_LAST_BIT);
  assign w_data    = r_shift[8:1];
  assign w_result  = frame_check(r_shift[0], w_data, r_shift[9], w_bit);
  assign w_good    = w_eval && (w_result == FR_GOOD);
  assign w_is_ext  = PREFIX_EN && (w_data == PS2_CODE_EXT);
  assign w_is_brk  = PREFIX_EN && (w_data == PS2_CODE_BRK);
  assign w_push    = w_good && !w_is_ext && !w_is_brk;
  assign w_entry   = {r_ext_pend, r_brk_pend, w_data};
  assign w_timeout = !w_fall && (r_bit_cnt != 4'd0) && (r_wd_cnt == WD_LIMIT);
  assign w_clear_pend = w_push || (w_eval && !w_good) || w_timeout;

  // Bit counter, shift buffer and stalled-frame watchdog.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bit_cnt <= 4'd0;
      r_shift   <= '0;
      r_wd_cnt  <= '0;
    end else if (w_fall) begin
      r_wd_cnt <= '0;
      if (r_bit_cnt == PS2_LAST_BIT) begin
        r_bit_cnt <= 4'd0;
      end else begin
        r_shift   <= {w_bit, r_shift[9:1]};
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
    end else if (r_bit_cnt != 4'd0) begin
      if (w_timeout) begin
        r_bit_cnt <= 4'd0;
        r_wd_cnt  <= '0;
      end else begin
        r_wd_cnt  <= r_wd_cnt + WDW'(1);
      end
    end
  end

  // Prefix flags: set by good E0/F0, consumed by the next pushed byte or any error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else if (w_clear_pend) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else begin
      if (w_good && w_is_ext) r_ext_pend <= 1'b1;
      if (w_good && w_is_brk) r_brk_pend <= 1'b1;
    end
  end

  // Registered one-cycle error pulses, one cycle after the evaluating fall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err_parity   <= 1'b0;
      r_err_frame    <= 1'b0;
      r_err_overflow <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_err_parity   <= w_eval && (w_result == FR_PARITY);
      r_err_frame    <= w_eval && (w_result == FR_FRAME);
      r_err_overflow <= w_push && !w_fifo_in_ready;
      r_err_timeout  <= w_timeout;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .in_data   (w_entry),
    .in_valid  (w_push),
    .in_ready  (w_fifo_in_ready),
    .out_data  (w_head),
    .out_valid (w_fifo_valid),
    .out_ready (out_ready),
    .level     (fifo_level)
  );

  // Head fields are forced to zero while empty so stale storage never shows.
  assign out_valid    = w_fifo_valid;
  assign out_data     = w_fifo_valid ? w_head[ENT_DATA_MSB:0] : 8'd0;
  assign out_ext      = w_fifo_valid & w_head[ENT_EXT];
  assign out_break    = w_fifo_valid & w_head[ENT_BRK];
  assign err_parity   = r_err_parity;
  assign err_frame    = r_err_frame;
  assign err_overflow = r_err_overflow;
  assign err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - scoreboard bench for ps2_rx_fifo
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

  logic       clk = 1'b0;
  logic       resetn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_ext;
  logic       out_break;
  logic [2:0] fifo_level;
  logic       err_parity;
  logic       err_frame;
  logic       err_overflow;
  logic       err_timeout;

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .FIFO_DEPTH     (4),
    .SYNC_STAGES    (3),
    .TIMEOUT_CYCLES (100),
    .DECODE_PREFIX  (1)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_ext      (out_ext),
    .out_break    (out_break),
    .fifo_level   (fifo_level),
    .err_parity   (err_parity),
    .err_frame    (err_frame),
    .err_overflow (err_overflow),
    .err_timeout  (err_timeout)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [9:0] exp_q[$];
  logic [9:0] r_exp;
  int cnt_par = 0, cnt_frm = 0, cnt_ovf = 0, cnt_to = 0;
  int exp_par = 0, exp_frm = 0, exp_ovf = 0, exp_to = 0;
  int n_valid_cyc = 0;
  int n_lvl_gt1 = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor samples on the falling edge; inputs change 1ns after the rising edge.
  always @(negedge clk) begin
    if (resetn) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("pop_with_empty_scoreboard", exp_q.size(), 1);
        end else begin
          r_exp = exp_q.pop_front();
          check_val("head_entry", {22'd0, out_ext, out_break, out_data}, {22'd0, r_exp});
        end
      end
      n_valid_cyc += int'(out_valid);
      n_lvl_gt1   += int'(fifo_level > 3'd1);
      cnt_par     += int'(err_parity);
      cnt_frm     += int'(err_frame);
      cnt_ovf     += int'(err_overflow);
      cnt_to      += int'(err_timeout);
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One PS/2 frame (or its first nbits), device drives data while ps2_clk is high.
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_bit,
                            input int nbits, input logic pop_at_eval);
    logic [10:0] fr;
    logic        par;
    par = bad_par ? (^d) : ~(^d);
    fr  = {stop_bit, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      step(10);
      ps2_clk = 1'b0;
      if (pop_at_eval && i == 10) begin
        step(2);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        step(17);
      end else begin
        step(20);
      end
      ps2_clk = 1'b1;
      step(10);
    end
    ps2_data = 1'b1;
    step(20);
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, 1'b0, 1'b1, 11, 1'b0);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step(1);
    check_val(tag, exp_q.size(), 0);
  endtask

  task automatic check_errs(input string tag);
    check_val({tag, "_err_parity"},   cnt_par, exp_par);
    check_val({tag, "_err_frame"},    cnt_frm, exp_frm);
    check_val({tag, "_err_overflow"}, cnt_ovf, exp_ovf);
    check_val({tag, "_err_timeout"},  cnt_to,  exp_to);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: observed expired expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int v0;
    int g0;
    resetn    = 1'b0;
    ps2_clk   = 1'b1;
    ps2_data  = 1'b1;
    out_ready = 1'b1;
    step(5);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_fifo_level", fifo_level, 0);
    check_val("rst_out_fields", {out_ext, out_break, out_data}, 0);
    check_val("rst_errors", {err_parity, err_frame, err_overflow, err_timeout}, 0);
    resetn = 1'b1;
    step(5);

    // Single good byte with immediate consumer.
    v0 = n_valid_cyc;
    exp_q.push_back({2'b00, 8'h1C});
    send_good(8'h1C);
    wait_drain("drain_1c");
    check_val("valid_cycles_1c", n_valid_cyc - v0, 1);
    check_errs("s1");

    // Extended break sequence merges into one entry.
    v0 = n_valid_cyc;
    g0 = n_lvl_gt1;
    send_good(8'hE0);
    send_good(8'hF0);
    check_val("no_entry_for_prefixes", n_valid_cyc - v0, 0);
    exp_q.push_back({2'b11, 8'h74});
    send_good(8'h74);
    wait_drain("drain_e0f074");
    check_val("valid_cycles_e0f074", n_valid_cyc - v0, 1);
    check_val("level_peak_over_1", n_lvl_gt1 - g0, 0);
    check_errs("s2");

    // Parity error drops the frame and clears the pending E0.
    v0 = n_valid_cyc;
    send_good(8'hE0);
    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
    exp_par++;
    check_val("no_entry_bad_parity", n_valid_cyc - v0, 0);
    check_errs("s3a");
    exp_q.push_back({2'b00, 8'h29});
    send_good(8'h29);
    wait_drain("drain_29_after_parity");
    check_errs("s3b");

    // Fill with consumer stalled, then overflow.
    out_ready = 1'b0;
    exp_q.push_back({2'b00, 8'h11});
    send_good(8'h11);
    exp_q.push_back({2'b00, 8'h22});
    send_good(8'h22);
    exp_q.push_back({2'b00, 8'h33});
    send_good(8'h33);
    exp_q.push_back({2'b00, 8'h44});
    send_good(8'h44);
    check_val("level_full", fifo_level, 4);
    send_good(8'h55);
    exp_ovf++;
    check_val("level_after_overflow", fifo_level, 4);
    check_val("head_after_overflow", out_data, 8'h11);
    check_errs("s4a");

    // Push and pop in the same cycle while full: no overflow, level unchanged.
    exp_q.push_back({2'b00, 8'h66});
    send_frame(8'h66, 1'b0, 1'b1, 11, 1'b1);
    check_val("level_push_pop_full", fifo_level, 4);
    check_val("head_after_push_pop", out_data, 8'h22);
    check_errs("s4b");
    out_ready = 1'b1;
    wait_drain("drain_after_full");
    check_val("level_drained", fifo_level, 0);

    // Abandoned partial frame triggers one watchdog pulse.
    send_frame(8'h29, 1'b0, 1'b1, 5, 1'b0);
    step(150);
    exp_to++;
    check_errs("s5a");
    exp_q.push_back({2'b00, 8'h29});
    send_good(8'h29);
    wait_drain("drain_29_after_timeout");
    check_errs("s5b");

    // Bad stop bit: framing error only.
    v0 = n_valid_cyc;
    send_frame(8'h5A, 1'b0, 1'b0, 11, 1'b0);
    exp_frm++;
    check_val("no_entry_bad_stop", n_valid_cyc - v0, 0);
    check_errs("s6");

    step(20);
    check_val("scoreboard_empty_at_end", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
